// File: rtl/puf_pkg.sv
// Shared definitions for the PUF sample sequencer.
//   - state_t        : sequencer FSM states
//   - PUF_DONE_STATE : puf_state encoding that means "response valid"
//   - *_LSB / *_W    : field placement inside an outgoing stream word
package puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TRIG     = 3'd1,
        ST_WAIT_PUF = 3'd2,
        ST_SEND     = 3'd3,
        ST_REARM    = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam logic [2:0] PUF_DONE_STATE = 3'b100;

    // Stream word layout; the response occupies [C_PUF_WIDTH-1:0], so the
    // PUF must be no wider than IDX_LSB and the word at least TO_BIT+1 wide.
    localparam int IDX_LSB  = 96;
    localparam int IDX_W    = 16;
    localparam int WAIT_LSB = 112;
    localparam int WAIT_W   = 16;
    localparam int TO_BIT   = 128;

    localparam logic [WAIT_W-1:0] WAIT_SAT = 16'hFFFF;

endpackage

// File: rtl/puf_wait_timer.sv
// Wait timer for one PUF evaluation.
//   aclk, areset : clock, async active-high reset
//   load         : start a new measurement (the loading cycle counts as one)
//   run          : advance by one cycle
//   count        : cycles elapsed since load, saturating at 16'hFFFF
//   timeout      : terminal count of the down-counter, C_TIMEOUT_CYCLES elapsed
module puf_wait_timer
    import puf_pkg::*;
#(
    parameter int C_TIMEOUT_CYCLES = 65535
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              load,
    input  logic              run,
    output logic [WAIT_W-1:0] count,
    output logic              timeout
);

    localparam int RW = (C_TIMEOUT_CYCLES < 2) ? 1 : $clog2(C_TIMEOUT_CYCLES + 1);

    logic [RW-1:0] remaining_q;
    logic [WAIT_W-1:0] count_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            remaining_q <= '0;
            count_q     <= '0;
        end else if (load) begin
            // the load cycle is the first elapsed cycle
            remaining_q <= RW'(C_TIMEOUT_CYCLES - 1);
            count_q     <= WAIT_W'(1);
        end else if (run) begin
            if (remaining_q != '0) begin
                remaining_q <= remaining_q - RW'(1);
            end
            if (count_q != WAIT_SAT) begin
                count_q <= count_q + WAIT_W'(1);
            end
        end
    end

    assign count   = count_q;
    assign timeout = (remaining_q == '0);

endmodule

// File: rtl/puf_sample_sequencer.sv
// Runs a configurable number of PUF evaluations and streams one word per
// evaluation (response, sample index, wait cycles, timeout flag).
//   aclk, areset          : clock, async active-high reset
//   ctrl_start            : start a run (IDLE only)
//   ctrl_num_samples      : evaluations per run, latched at start
//   ctrl_busy / ctrl_done : run in progress / one-cycle end pulse
//   ctrl_timeout_err      : sticky timeout, cleared by the next start
//   puf_trig              : PUF enable
//   puf_state, puf_out    : PUF progress and response
//   m_axis_*              : outgoing stream words
//
// state    | meaning
// IDLE     | waiting for ctrl_start
// TRIG     | puf_trig rises, wait timer loaded
// WAIT_PUF | puf_trig held, waiting for response or timeout
// SEND     | word presented on the stream until accepted
// REARM    | puf_trig held low before the next evaluation
// DONE     | one-cycle done pulse
module puf_sample_sequencer
    import puf_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_PUF_WIDTH        = 96,
    parameter int C_TIMEOUT_CYCLES   = 65535,
    parameter int C_REARM_CYCLES     = 4
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          ctrl_start,
    input  logic [15:0]                   ctrl_num_samples,
    output logic                          ctrl_busy,
    output logic                          ctrl_done,
    output logic                          ctrl_timeout_err,
    output logic                          puf_trig,
    input  logic [2:0]                    puf_state,
    input  logic [C_PUF_WIDTH-1:0]        puf_out,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] m_axis_tdata
);

    localparam int RAW = (C_REARM_CYCLES < 2) ? 1 : $clog2(C_REARM_CYCLES + 1);

    state_t state_q, state_d;

    logic [15:0]                   num_samples_q;
    logic [IDX_W-1:0]              index_q;
    logic                          timeout_err_q;
    logic [C_M_AXI_DATA_WIDTH-1:0] tdata_q;
    logic [RAW-1:0]                rearm_cnt_q;
    logic [C_M_AXI_DATA_WIDTH-1:0] word_d;

    logic              timer_load;
    logic              timer_run;
    logic [WAIT_W-1:0] wait_count;
    logic              wait_timeout;
    logic              puf_ready;
    logic              last_sample;

    assign puf_ready   = (puf_state == PUF_DONE_STATE);
    assign last_sample = ((index_q + IDX_W'(1)) == num_samples_q);

    puf_wait_timer #(
        .C_TIMEOUT_CYCLES(C_TIMEOUT_CYCLES)
    ) u_wait_timer (
        .aclk   (aclk),
        .areset (areset),
        .load   (timer_load),
        .run    (timer_run),
        .count  (wait_count),
        .timeout(wait_timeout)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_load    = 1'b0;
        timer_run     = 1'b0;
        puf_trig      = 1'b0;
        m_axis_tvalid = 1'b0;
        ctrl_busy     = 1'b1;
        ctrl_done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ctrl_busy = 1'b0;
                if (ctrl_start) begin
                    state_d = (ctrl_num_samples == 16'd0) ? ST_DONE : ST_TRIG;
                end
            end
            ST_TRIG: begin
                puf_trig   = 1'b1;
                timer_load = 1'b1;
                state_d    = ST_WAIT_PUF;
            end
            ST_WAIT_PUF: begin
                puf_trig  = 1'b1;
                timer_run = 1'b1;
                if (puf_ready || wait_timeout) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                m_axis_tvalid = 1'b1;
                if (m_axis_tready) begin
                    state_d = (tdata_q[TO_BIT] || last_sample) ? ST_DONE : ST_REARM;
                end
            end
            ST_REARM: begin
                if (rearm_cnt_q == '0) begin
                    state_d = ST_TRIG;
                end
            end
            ST_DONE: begin
                ctrl_done = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A ready response wins over a timeout landing on the same cycle.
    always_comb begin
        word_d = '0;
        if (puf_ready) begin
            word_d[C_PUF_WIDTH-1:0] = puf_out;
        end
        word_d[IDX_LSB +: IDX_W]   = index_q;
        word_d[WAIT_LSB +: WAIT_W] = wait_count;
        word_d[TO_BIT]             = ~puf_ready;
    end

    // The rearm counter starts when puf_trig falls, so the SEND cycle counts
    // toward the low time; with an accepting sink the low time is exactly
    // C_REARM_CYCLES, a stalled sink only lengthens it.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            num_samples_q <= '0;
            index_q       <= '0;
            timeout_err_q <= 1'b0;
            tdata_q       <= '0;
            rearm_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ctrl_start) begin
                        num_samples_q <= ctrl_num_samples;
                        index_q       <= '0;
                        timeout_err_q <= 1'b0;
                    end
                end
                ST_WAIT_PUF: begin
                    if (puf_ready || wait_timeout) begin
                        tdata_q     <= word_d;
                        rearm_cnt_q <= RAW'(C_REARM_CYCLES - 1);
                        if (!puf_ready) begin
                            timeout_err_q <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (rearm_cnt_q != '0) begin
                        rearm_cnt_q <= rearm_cnt_q - RAW'(1);
                    end
                    if (m_axis_tready && !tdata_q[TO_BIT] && !last_sample) begin
                        index_q <= index_q + IDX_W'(1);
                    end
                end
                ST_REARM: begin
                    if (rearm_cnt_q != '0) begin
                        rearm_cnt_q <= rearm_cnt_q - RAW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ctrl_timeout_err = timeout_err_q;
    assign m_axis_tdata     = tdata_q;

endmodule

// File: tb/tb_puf_sample_sequencer.sv
module tb_puf_sample_sequencer;

    localparam int DW    = 512;
    localparam int PW    = 96;
    localparam int TMO   = 100;
    localparam int REARM = 4;
    localparam int DELAY = 10;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          ctrl_start = 1'b0;
    logic [15:0]   ctrl_num_samples = 16'd0;
    logic          ctrl_busy;
    logic          ctrl_done;
    logic          ctrl_timeout_err;
    logic          puf_trig;
    logic [2:0]    puf_state = 3'b000;
    logic [PW-1:0] puf_out = '0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [DW-1:0] m_axis_tdata;

    puf_sample_sequencer #(
        .C_M_AXI_DATA_WIDTH(DW),
        .C_PUF_WIDTH       (PW),
        .C_TIMEOUT_CYCLES  (TMO),
        .C_REARM_CYCLES    (REARM)
    ) dut (
        .aclk            (aclk),
        .areset          (areset),
        .ctrl_start      (ctrl_start),
        .ctrl_num_samples(ctrl_num_samples),
        .ctrl_busy       (ctrl_busy),
        .ctrl_done       (ctrl_done),
        .ctrl_timeout_err(ctrl_timeout_err),
        .puf_trig        (puf_trig),
        .puf_state       (puf_state),
        .puf_out         (puf_out),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tdata    (m_axis_tdata)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] exp_q[$];
    int xfer_cnt = 0;
    int done_cnt = 0;
    int low_run  = 0;
    bit seen_trig = 1'b0;
    int low_runs[$];

    int age    = 0;
    int eval_n = 0;
    bit never_ready = 1'b0;

    function automatic logic [PW-1:0] puf_pattern(input int n);
        logic [31:0] k;
        k = 32'(n);
        return {32'hC0DE_0000 ^ k, 32'h1234_5678 + k, ~k};
    endfunction

    function automatic logic [DW-1:0] exp_word(input logic [PW-1:0] resp, input logic [15:0] idx,
                                               input logic [15:0] wt, input logic to);
        logic [DW-1:0] w;
        w = '0;
        w[95:0]    = resp;
        w[111:96]  = idx;
        w[127:112] = wt;
        w[128]     = to;
        return w;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // PUF model: response valid on the DELAY-th cycle after trig rose
    always @(negedge aclk) begin
        if (puf_trig) begin
            age++;
            if (age == 1) begin
                puf_out = puf_pattern(eval_n);
                eval_n++;
            end
            if (!never_ready && age == DELAY + 1) begin
                puf_state = 3'b100;
            end else begin
                case (age % 3)
                    0:       puf_state = 3'b011;
                    1:       puf_state = 3'b101;
                    default: puf_state = 3'b110;
                endcase
            end
        end else begin
            age = 0;
            puf_state = 3'b000;
        end
    end

    // Monitor: scoreboard pop on transfer, done pulses, trig low runs
    always @(negedge aclk) begin
        #1;
        if (ctrl_done) done_cnt++;
        if (m_axis_tvalid && m_axis_tready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL word_unexpected: got %0h expected no word", m_axis_tdata);
            end else begin
                check("stream_word", m_axis_tdata, exp_q.pop_front());
            end
        end
        if (!ctrl_busy) begin
            seen_trig = 1'b0;
            low_run = 0;
        end else if (puf_trig) begin
            if (seen_trig && low_run > 0) low_runs.push_back(low_run);
            seen_trig = 1'b1;
            low_run = 0;
        end else if (seen_trig) begin
            low_run++;
        end
    end

    task automatic start_run(input logic [15:0] n);
        @(negedge aclk);
        ctrl_num_samples = n;
        ctrl_start = 1'b1;
        @(negedge aclk);
        ctrl_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        int i;
        d0 = done_cnt;
        i = 0;
        while (done_cnt == d0 && i < budget) begin
            @(negedge aclk);
            #2;
            i++;
        end
        total++;
        if (done_cnt == d0) begin
            bad++;
            $display("FAIL %s: got no done pulse expected one within %0d cycles", name, budget);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int x0;
        int i;
        logic [DW-1:0] snap;
        bit stable;

        // reset state
        repeat (3) @(negedge aclk);
        #2;
        check("rst_trig", puf_trig, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_busy", ctrl_busy, 0);
        check("rst_done", ctrl_done, 0);
        check("rst_err", ctrl_timeout_err, 0);
        @(negedge aclk);
        areset = 1'b0;
        repeat (2) @(negedge aclk);

        // three samples, sink always ready, mid-run start pulses ignored
        low_runs.delete();
        d0 = done_cnt;
        x0 = xfer_cnt;
        m_axis_tready = 1'b1;
        never_ready = 1'b0;
        for (int k = 0; k < 3; k++) exp_q.push_back(exp_word(puf_pattern(eval_n + k), 16'(k), 16'd10, 1'b0));
        start_run(16'd3);
        check("A_busy", ctrl_busy, 1);
        repeat (4) @(negedge aclk);
        ctrl_num_samples = 16'd7;
        ctrl_start = 1'b1;
        @(negedge aclk);
        ctrl_start = 1'b0;
        i = 0;
        while (xfer_cnt == x0 && i < 60) begin
            @(negedge aclk);
            #2;
            i++;
        end
        check("A_first_xfer_seen", xfer_cnt - x0, 1);
        ctrl_num_samples = 16'd0;
        ctrl_start = 1'b1;
        repeat (2) @(negedge aclk);
        ctrl_start = 1'b0;
        wait_done("A_done", 200);
        repeat (3) @(negedge aclk);
        #2;
        check("A_words", xfer_cnt - x0, 3);
        check("A_done_pulses", done_cnt - d0, 1);
        check("A_timeout_err", ctrl_timeout_err, 0);
        check("A_busy_after", ctrl_busy, 0);
        check("A_rearm_runs", low_runs.size(), 2);
        foreach (low_runs[k]) check("A_rearm_len", low_runs[k], REARM);

        // stalled sink: word held stable for 20 cycles
        m_axis_tready = 1'b0;
        x0 = xfer_cnt;
        exp_q.push_back(exp_word(puf_pattern(eval_n), 16'd0, 16'd10, 1'b0));
        start_run(16'd1);
        i = 0;
        while (!m_axis_tvalid && i < 60) begin
            @(negedge aclk);
            #2;
            i++;
        end
        check("B_tvalid_seen", m_axis_tvalid, 1);
        snap = m_axis_tdata;
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge aclk);
            #2;
            if (!m_axis_tvalid || m_axis_tdata !== snap) stable = 1'b0;
        end
        check("B_stall_stable", stable, 1);
        check("B_no_xfer_in_stall", xfer_cnt - x0, 0);
        @(negedge aclk);
        m_axis_tready = 1'b1;
        wait_done("B_done", 20);
        check("B_single_xfer", xfer_cnt - x0, 1);
        check("B_tvalid_low", m_axis_tvalid, 0);

        // PUF never ready: timeout word, sticky error
        never_ready = 1'b1;
        d0 = done_cnt;
        x0 = xfer_cnt;
        exp_q.push_back(exp_word('0, 16'd0, 16'(TMO), 1'b1));
        start_run(16'd2);
        wait_done("C_done", 400);
        #2;
        check("C_err_set", ctrl_timeout_err, 1);
        check("C_trig_low", puf_trig, 0);
        check("C_one_word", xfer_cnt - x0, 1);
        check("C_done_pulses", done_cnt - d0, 1);
        repeat (3) @(negedge aclk);
        #2;
        check("C_err_sticky", ctrl_timeout_err, 1);
        never_ready = 1'b0;

        // zero samples: done in the cycle after the start cycle, no word
        x0 = xfer_cnt;
        @(negedge aclk);
        ctrl_num_samples = 16'd0;
        ctrl_start = 1'b1;
        @(negedge aclk);
        ctrl_start = 1'b0;
        #2;
        check("D_done_pulse", ctrl_done, 1);
        check("D_err_cleared", ctrl_timeout_err, 0);
        check("D_tvalid", m_axis_tvalid, 0);
        @(negedge aclk);
        #2;
        check("D_done_one_cycle", ctrl_done, 0);
        check("D_busy_low", ctrl_busy, 0);
        check("D_no_words", xfer_cnt - x0, 0);

        // reset while waiting on the PUF
        d0 = done_cnt;
        start_run(16'd2);
        i = 0;
        while (!puf_trig && i < 20) begin
            @(negedge aclk);
            i++;
        end
        repeat (4) @(negedge aclk);
        #2;
        check("E_in_wait", puf_trig, 1);
        areset = 1'b1;
        #1;
        check("E_rst_trig", puf_trig, 0);
        check("E_rst_tvalid", m_axis_tvalid, 0);
        check("E_rst_busy", ctrl_busy, 0);
        check("E_rst_done", ctrl_done, 0);
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        #2;
        check("E_no_done", done_cnt - d0, 0);
        x0 = xfer_cnt;
        d0 = done_cnt;
        exp_q.push_back(exp_word(puf_pattern(eval_n), 16'd0, 16'd10, 1'b0));
        start_run(16'd1);
        wait_done("E_rerun_done", 100);
        check("E_rerun_word", xfer_cnt - x0, 1);
        check("E_rerun_done_pulses", done_cnt - d0, 1);

        repeat (2) @(negedge aclk);
        #2;
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
